// File: rtl/data_req_issuer.sv
// EXE-side initiator for the data SRAM-like port: issues aligned load/store requests,
// allows one access in flight, and swallows data_ok for requests killed by a WB flush.
module data_req_issuer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_valid,
  input  logic [7:0]        es_mem_op,
  input  logic [ADDR_W-1:0] es_addr,
  input  logic [31:0]       es_st_data,
  input  logic              ms_allowin,
  input  logic              wb_ex,
  input  logic              wb_ertn,
  output logic              issue_ready,
  output logic              ale,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  output logic              ms_data_ok,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t      state;
  logic        flush;
  logic        flush_pend;
  logic        is_half;
  logic        is_word;
  logic        is_store;
  logic        has_op;
  logic        start;
  logic [1:0]  off;
  logic [1:0]  size_n;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;

  // one-hot order: {st_b, st_h, st_w, ld_b, ld_bu, ld_h, ld_hu, ld_w}
  assign flush    = wb_ex | wb_ertn;
  assign is_half  = es_mem_op[6] | es_mem_op[2] | es_mem_op[1];
  assign is_word  = es_mem_op[5] | es_mem_op[0];
  assign is_store = |es_mem_op[7:5];
  assign has_op   = |es_mem_op;
  assign off      = es_addr[1:0];

  assign ale   = es_valid & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign start = es_valid & has_op & ~ale & ms_allowin & ~flush;

  always_comb begin
    size_n  = 2'd0;
    wstrb_n = '0;
    wdata_n = es_st_data;
    if (is_word)      size_n = 2'd2;
    else if (is_half) size_n = 2'd1;
    if (es_mem_op[7]) begin
      wdata_n = {4{es_st_data[7:0]}};
      wstrb_n = 4'b0001 << off;
    end else if (es_mem_op[6]) begin
      wdata_n = {2{es_st_data[15:0]}};
      wstrb_n = 4'b0011 << off;
    end else if (es_mem_op[5]) begin
      wstrb_n = 4'b1111;
    end
  end

  always_comb begin
    issue_ready = 1'b0;
    unique case (state)
      IDLE:    issue_ready = es_valid & (~has_op | ale) & ~flush;
      REQ:     issue_ready = data_sram_addr_ok & ~flush & ~flush_pend;
      default: issue_ready = 1'b0;
    endcase
  end

  assign data_sram_req = (state == REQ);
  assign busy          = (state != IDLE);
  assign ms_data_ok    = (state == WAIT) & data_sram_data_ok & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      flush_pend      <= 1'b0;
      data_sram_wr    <= 1'b0;
      data_sram_size  <= '0;
      data_sram_wstrb <= '0;
      data_sram_addr  <= '0;
      data_sram_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state           <= REQ;
            data_sram_wr    <= is_store;
            data_sram_size  <= size_n;
            data_sram_wstrb <= wstrb_n;
            data_sram_addr  <= es_addr;
            data_sram_wdata <= wdata_n;
          end
        end
        REQ: begin
          // req is never withdrawn; a flush seen while waiting for addr_ok is remembered
          if (data_sram_addr_ok) begin
            state      <= (flush | flush_pend) ? DISCARD : WAIT;
            flush_pend <= 1'b0;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        WAIT: begin
          if (data_sram_data_ok)  state <= IDLE;
          else if (flush)         state <= DISCARD;
        end
        DISCARD: begin
          if (data_sram_data_ok)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_req_issuer.sv
// Scoreboard bench for data_req_issuer: expected requests and data_ok forwarding are
// queued as stimulus is driven and compared when the DUT presents them.
module tb_data_req_issuer;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_valid;
  logic [7:0]  es_mem_op;
  logic [31:0] es_addr;
  logic [31:0] es_st_data;
  logic        ms_allowin;
  logic        wb_ex;
  logic        wb_ertn;
  logic        issue_ready;
  logic        ale;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic        ms_data_ok;
  logic        busy;

  int   tests = 0;
  int   fails = 0;
  req_t req_q[$];
  logic dok_q[$];
  req_t mon_e;
  logic mon_d;

  localparam logic [7:0] ST_B = 8'h80, ST_H = 8'h40, ST_W = 8'h20, LD_B = 8'h10,
                         LD_BU = 8'h08, LD_H = 8'h04, LD_HU = 8'h02, LD_W = 8'h01;

  data_req_issuer #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .es_valid(es_valid), .es_mem_op(es_mem_op),
    .es_addr(es_addr), .es_st_data(es_st_data), .ms_allowin(ms_allowin),
    .wb_ex(wb_ex), .wb_ertn(wb_ertn), .issue_ready(issue_ready), .ale(ale),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .ms_data_ok(ms_data_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: accepted requests and every data_ok return.
  always @(negedge clk) begin
    #2;
    if (data_sram_req === 1'b1 && data_sram_addr_ok === 1'b1) begin
      tests++;
      if (req_q.size() == 0) begin
        fails++;
        $display("FAIL req_unexpected: got addr=%h, required no request", data_sram_addr);
      end else begin
        mon_e = req_q.pop_front();
        if (data_sram_wr !== mon_e.wr || data_sram_size !== mon_e.size ||
            data_sram_wstrb !== mon_e.wstrb || data_sram_addr !== mon_e.addr ||
            (mon_e.wr && data_sram_wdata !== mon_e.wdata)) begin
          fails++;
          $display("FAIL req_fields: got wr=%b size=%0d wstrb=%b addr=%h wdata=%h, required wr=%b size=%0d wstrb=%b addr=%h wdata=%h",
                   data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
                   mon_e.wr, mon_e.size, mon_e.wstrb, mon_e.addr, mon_e.wdata);
        end
      end
    end
    if (data_sram_data_ok === 1'b1) begin
      tests++;
      if (dok_q.size() == 0) begin
        fails++;
        $display("FAIL dok_unexpected: got ms_data_ok=%b, required no data_ok", ms_data_ok);
      end else begin
        mon_d = dok_q.pop_front();
        if (ms_data_ok !== mon_d) begin
          fails++;
          $display("FAIL ms_data_ok: got %b, required %b", ms_data_ok, mon_d);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic quiet();
    es_valid = 1'b0; es_mem_op = '0; es_addr = '0; es_st_data = '0;
    wb_ex = 1'b0; wb_ertn = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    ms_allowin = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; quiet();
    step(); step();
    #1; tests++;
    if ({issue_ready, ale, data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
         data_sram_addr, data_sram_wdata, ms_data_ok, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b busy=%b addr=%h wdata=%h, required all 0",
               data_sram_req, busy, data_sram_addr, data_sram_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_st_b();
    step();
    es_valid = 1'b1; es_mem_op = ST_B; es_addr = 32'h1003; es_st_data = 32'h12345678;
    req_q.push_back('{1'b1, 2'd0, 4'b1000, 32'h1003, 32'h78787878});
    #1; tests++;
    if (issue_ready !== 1'b0 || data_sram_req !== 1'b0 || ale !== 1'b0) begin
      fails++; $display("FAIL stb_present: got ir=%b req=%b ale=%b, required 0 0 0", issue_ready, data_sram_req, ale);
    end
    step(); data_sram_addr_ok = 1'b1;
    #1; tests++;
    if (data_sram_req !== 1'b1 || issue_ready !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL stb_req: got req=%b ir=%b busy=%b, required 1 1 1", data_sram_req, issue_ready, busy);
    end
    step(); quiet();
    #1; tests++;
    if (data_sram_req !== 1'b0 || issue_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL stb_wait: got req=%b ir=%b busy=%b, required 0 0 1", data_sram_req, issue_ready, busy);
    end
    step(); data_sram_data_ok = 1'b1; dok_q.push_back(1'b1);
    step(); data_sram_data_ok = 1'b0;
    #1; tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL stb_idle: got busy=%b, required 0", busy); end
  endtask

  task automatic test_st_h_stall();
    step();
    es_valid = 1'b1; es_mem_op = ST_H; es_addr = 32'h2002; es_st_data = 32'hAABBCCDD;
    req_q.push_back('{1'b1, 2'd1, 4'b1100, 32'h2002, 32'hCCDDCCDD});
    for (int i = 0; i < 4; i++) begin
      step();
      data_sram_addr_ok = (i == 3);
      es_st_data = 32'hDEAD0000 + i;
      #1; tests++;
      if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata}
          !== {1'b1, 1'b1, 2'd1, 4'b1100, 32'h2002, 32'hCCDDCCDD} || issue_ready !== (i == 3)) begin
        fails++;
        $display("FAIL sth_stable[%0d]: got req=%b wstrb=%b addr=%h wdata=%h ir=%b, required 1 1100 00002002 ccddccdd %b",
                 i, data_sram_req, data_sram_wstrb, data_sram_addr, data_sram_wdata, issue_ready, (i == 3));
      end
    end
    step(); quiet();
    step(); data_sram_data_ok = 1'b1; dok_q.push_back(1'b1);
    step(); data_sram_data_ok = 1'b0;
  endtask

  task automatic test_ale();
    step();
    es_valid = 1'b1; es_mem_op = LD_W; es_addr = 32'h3001;
    #1; tests++;
    if (ale !== 1'b1 || issue_ready !== 1'b1 || data_sram_req !== 1'b0) begin
      fails++; $display("FAIL ale_ldw: got ale=%b ir=%b req=%b, required 1 1 0", ale, issue_ready, data_sram_req);
    end
    step(); es_mem_op = LD_H; es_addr = 32'h3003;
    #1; tests++;
    if (ale !== 1'b1 || busy !== 1'b0 || data_sram_req !== 1'b0) begin
      fails++; $display("FAIL ale_ldh: got ale=%b busy=%b req=%b, required 1 0 0", ale, busy, data_sram_req);
    end
    step(); es_mem_op = ST_W; es_addr = 32'h3002; ms_allowin = 1'b0;
    #1; tests++;
    if (ale !== 1'b1) begin fails++; $display("FAIL ale_stw: got ale=%b, required 1", ale); end
    step(); es_mem_op = LD_HU; es_addr = 32'h3002;
    #1; tests++;
    if (ale !== 1'b0 || issue_ready !== 1'b0) begin
      fails++; $display("FAIL ale_aligned_blocked: got ale=%b ir=%b, required 0 0", ale, issue_ready);
    end
    step(); es_valid = 1'b0; es_mem_op = LD_W; es_addr = 32'h3001;
    #1; tests++;
    if (ale !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL ale_invalid: got ale=%b busy=%b, required 0 0", ale, busy);
    end
    step(); quiet();
  endtask

  task automatic test_flush_wait();
    step();
    es_valid = 1'b1; es_mem_op = LD_W; es_addr = 32'h4000;
    req_q.push_back('{1'b0, 2'd2, 4'b0000, 32'h4000, 32'h0});
    step(); data_sram_addr_ok = 1'b1;
    step(); quiet(); wb_ex = 1'b1;
    #1; tests++;
    if (issue_ready !== 1'b0 || ms_data_ok !== 1'b0) begin
      fails++; $display("FAIL fw_flush: got ir=%b msdok=%b, required 0 0", issue_ready, ms_data_ok);
    end
    step(); wb_ex = 1'b0;
    #1; tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL fw_discard: got busy=%b, required 1", busy); end
    step(); data_sram_data_ok = 1'b1; dok_q.push_back(1'b0);
    step(); data_sram_data_ok = 1'b0;
    #1; tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL fw_idle: got busy=%b, required 0", busy); end
    es_valid = 1'b1; es_mem_op = ST_W; es_addr = 32'h4004; es_st_data = 32'h11223344;
    req_q.push_back('{1'b1, 2'd2, 4'b1111, 32'h4004, 32'h11223344});
    step(); data_sram_addr_ok = 1'b1;
    #1; tests++;
    if (issue_ready !== 1'b1) begin fails++; $display("FAIL fw_next_issue: got ir=%b, required 1", issue_ready); end
    step(); quiet();
    step(); data_sram_data_ok = 1'b1; dok_q.push_back(1'b1);
    step(); data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_req();
    step();
    es_valid = 1'b1; es_mem_op = LD_BU; es_addr = 32'h5003;
    req_q.push_back('{1'b0, 2'd0, 4'b0000, 32'h5003, 32'h0});
    step(); wb_ertn = 1'b1;
    #1; tests++;
    if (data_sram_req !== 1'b1 || issue_ready !== 1'b0) begin
      fails++; $display("FAIL fr_ertn: got req=%b ir=%b, required 1 0", data_sram_req, issue_ready);
    end
    step(); wb_ertn = 1'b0; es_valid = 1'b0;
    #1; tests++;
    if (data_sram_req !== 1'b1) begin fails++; $display("FAIL fr_hold: got req=%b, required 1", data_sram_req); end
    step(); data_sram_addr_ok = 1'b1;
    #1; tests++;
    if (data_sram_req !== 1'b1 || issue_ready !== 1'b0) begin
      fails++; $display("FAIL fr_addr_ok: got req=%b ir=%b, required 1 0", data_sram_req, issue_ready);
    end
    step(); quiet();
    #1; tests++;
    if (data_sram_req !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL fr_discard: got req=%b busy=%b, required 0 1", data_sram_req, busy);
    end
    step(); data_sram_data_ok = 1'b1; dok_q.push_back(1'b0);
    step(); data_sram_data_ok = 1'b0;
    // flush coincident with addr_ok, then flush coincident with data_ok in WAIT
    es_valid = 1'b1; es_mem_op = LD_H; es_addr = 32'h5002;
    req_q.push_back('{1'b0, 2'd1, 4'b0000, 32'h5002, 32'h0});
    step(); data_sram_addr_ok = 1'b1; wb_ex = 1'b1;
    #1; tests++;
    if (issue_ready !== 1'b0) begin fails++; $display("FAIL fr_same_cycle: got ir=%b, required 0", issue_ready); end
    step(); quiet();
    step(); data_sram_data_ok = 1'b1; dok_q.push_back(1'b0);
    step(); data_sram_data_ok = 1'b0;
    es_valid = 1'b1; es_mem_op = LD_B; es_addr = 32'h5001;
    req_q.push_back('{1'b0, 2'd0, 4'b0000, 32'h5001, 32'h0});
    step(); data_sram_addr_ok = 1'b1;
    step(); quiet(); wb_ex = 1'b1; data_sram_data_ok = 1'b1; dok_q.push_back(1'b0);
    step(); quiet();
    #1; tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL fr_flush_dok: got busy=%b, required 0", busy); end
    data_sram_data_ok = 1'b1; dok_q.push_back(1'b0);
    step(); quiet();
    #1; tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL stray_dok: got busy=%b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    step();
    es_valid = 1'b1; es_mem_op = ST_B; es_addr = 32'h7001; es_st_data = 32'h000000A5;
    req_q.push_back('{1'b1, 2'd0, 4'b0010, 32'h7001, 32'hA5A5A5A5});
    step(); data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0; es_mem_op = LD_HU; es_addr = 32'h7002;
    #1; tests++;
    if (issue_ready !== 1'b0 || data_sram_req !== 1'b0) begin
      fails++; $display("FAIL b2b_wait: got ir=%b req=%b, required 0 0", issue_ready, data_sram_req);
    end
    step(); data_sram_data_ok = 1'b1; dok_q.push_back(1'b1);
    req_q.push_back('{1'b0, 2'd1, 4'b0000, 32'h7002, 32'h0});
    step(); data_sram_data_ok = 1'b0;
    #1; tests++;
    if (data_sram_req !== 1'b0 || issue_ready !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_present: got req=%b ir=%b busy=%b, required 0 0 0", data_sram_req, issue_ready, busy);
    end
    step(); data_sram_addr_ok = 1'b1;
    #1; tests++;
    if (data_sram_req !== 1'b1 || issue_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_issue: got req=%b ir=%b, required 1 1", data_sram_req, issue_ready);
    end
    step(); quiet();
    step(); data_sram_data_ok = 1'b1; dok_q.push_back(1'b1);
    step(); data_sram_data_ok = 1'b0;
  endtask

  task automatic test_reset_wait();
    step();
    es_valid = 1'b1; es_mem_op = LD_W; es_addr = 32'h6000;
    req_q.push_back('{1'b0, 2'd2, 4'b0000, 32'h6000, 32'h0});
    step(); data_sram_addr_ok = 1'b1;
    step(); quiet(); reset = 1'b1;
    step(); reset = 1'b0;
    #1; tests++;
    if ({issue_ready, ale, data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
         data_sram_addr, data_sram_wdata, ms_data_ok, busy} !== '0) begin
      fails++;
      $display("FAIL rw_outputs: got req=%b busy=%b addr=%h size=%0d, required all 0",
               data_sram_req, busy, data_sram_addr, data_sram_size);
    end
    data_sram_data_ok = 1'b1; dok_q.push_back(1'b0);
    step(); data_sram_data_ok = 1'b0;
    #1; tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rw_late_dok: got busy=%b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_st_b();
    test_st_h_stall();
    test_ale();
    test_flush_wait();
    test_flush_req();
    test_back_to_back();
    test_reset_wait();
    step(); step();
    tests++;
    if (req_q.size() != 0 || dok_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d reqs %0d data_ok pending, required 0 0", req_q.size(), dok_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
